// File: rtl/wshb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wshb_ram_slave
// Brief    : Wishbone B4 RAM responder with classic cycles and incrementing
//            bursts. Optional WSHB_RAM_ERR_EN flags out-of-range addresses.
// Revision : 1.0 - initial release
// ============================================================================
module wshb_ram_slave #(
    parameter int DEPTH_LOG2 = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    input  logic [3:0]  sel,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic [31:0] dat_sm,
    output logic        ack,
    output logic        err,
    output logic        rty
);

    localparam int c_aw    = DEPTH_LOG2;
    localparam int c_depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_BURST  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_ack_q;
    logic              w_ack_nx;
    logic              r_err_q;
    logic              w_err_nx;
    logic [c_aw-1:0]   r_addr;
    logic [c_aw-1:0]   w_addr_nx;
    logic [c_aw-1:0]   w_adr_word;
    logic [c_aw-1:0]   w_wr_addr;
    logic [c_aw-1:0]   w_rd_addr;
    logic [c_aw-1:0]   w_burst_nx;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_req;
    logic              w_oor;
    logic              w_cross;
    logic [31:0]       r_dat;
    logic [31:0]       w_rd_data;
    logic [31:0]       r_mem [c_depth];
    logic              w_unused;

    // Wrap modes only advance the low bits selected by the mask.
    function automatic logic [c_aw-1:0] f_next_addr(input logic [c_aw-1:0] a,
                                                    input logic [1:0]      b);
        logic [c_aw-1:0] m;
        case (b)
            2'b01:   m = c_aw'(3);
            2'b10:   m = c_aw'(7);
            2'b11:   m = c_aw'(15);
            default: m = '1;
        endcase
        return (a & ~m) | ((a + c_aw'(1)) & m);
    endfunction

    assign w_req      = cyc & stb;
    assign w_adr_word = adr[c_aw+1:2];
    assign w_burst_nx = f_next_addr(r_addr, bte);

`ifdef WSHB_RAM_ERR_EN
    assign w_oor    = |adr[31:c_aw+2];
    assign w_cross  = (bte == 2'b00) && (&r_addr);
    assign err      = r_err_q & cyc & stb;
    assign w_unused = &{1'b0, adr[1:0], (INIT_ZERO != 0)};
`else
    assign w_oor    = 1'b0;
    assign w_cross  = 1'b0;
    assign err      = 1'b0;
    assign w_unused = &{1'b0, adr[1:0], adr[31:c_aw+2], r_err_q, (INIT_ZERO != 0)};
`endif

    assign ack    = r_ack_q & cyc & stb;
    assign rty    = 1'b0;
    assign dat_sm = r_dat;

    always_comb begin
        w_state_nx = r_state;
        w_ack_nx   = r_ack_q;
        w_err_nx   = r_err_q;
        w_addr_nx  = r_addr;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_addr;
        w_rd_en    = 1'b0;
        w_rd_addr  = r_addr;
        case (r_state)
            S_IDLE: begin
                w_ack_nx = 1'b0;
                w_err_nx = 1'b0;
                if (w_req) begin
                    w_addr_nx = w_adr_word;
                    if (w_oor) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_SINGLE;
                    end else begin
                        w_ack_nx   = 1'b1;
                        w_wr_en    = we;
                        w_wr_addr  = w_adr_word;
                        w_rd_en    = ~we;
                        w_rd_addr  = w_adr_word;
                        w_state_nx = (cti == 3'b010) ? S_BURST : S_SINGLE;
                    end
                end
            end
            S_SINGLE: begin
                w_ack_nx   = 1'b0;
                w_err_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
            S_BURST: begin
                if (!cyc) begin
                    w_ack_nx   = 1'b0;
                    w_err_nx   = 1'b0;
                    w_state_nx = S_IDLE;
                end else if (stb) begin
                    // The acked beat writes at r_addr; data for the following beat is fetched.
                    w_wr_en = we;
                    if (cti == 3'b111) begin
                        w_ack_nx   = 1'b0;
                        w_state_nx = S_IDLE;
                    end else if (w_cross) begin
                        w_ack_nx   = 1'b0;
                        w_err_nx   = 1'b1;
                        w_state_nx = S_SINGLE;
                    end else begin
                        w_addr_nx = w_burst_nx;
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_burst_nx;
                    end
                end
            end
            default: begin
                w_ack_nx   = 1'b0;
                w_err_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Write-first: a same-edge write to the read address is forwarded lane by lane.
    always_comb begin
        w_rd_data = r_mem[w_rd_addr];
        if (w_wr_en && (w_wr_addr == w_rd_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    w_rd_data[8*i +: 8] = dat_ms[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_en && sys_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    r_mem[w_wr_addr][8*i +: 8] <= dat_ms[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_ack_q <= 1'b0;
            r_err_q <= 1'b0;
            r_addr  <= '0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ack_q <= w_ack_nx;
            r_err_q <= w_err_nx;
            r_addr  <= w_addr_nx;
            if (w_rd_en) begin
                r_dat <= w_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wshb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_ram_slave
// Brief    : Self-checking bench for wshb_ram_slave (vector table, directed
//            bursts, randomized traffic against a word-array memory model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_ram_slave;

    localparam int DL2   = 10;
    localparam int DEPTH = 1 << DL2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack, err, rty;

    always #5 sys_clk = ~sys_clk;

    wshb_ram_slave #(.DEPTH_LOG2(DL2), .INIT_ZERO(1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cyc       (cyc),
        .stb       (stb),
        .we        (we),
        .adr       (adr),
        .dat_ms    (dat_ms),
        .sel       (sel),
        .cti       (cti),
        .bte       (bte),
        .dat_sm    (dat_sm),
        .ack       (ack),
        .err       (err),
        .rty       (rty)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] bdat [16];
    logic [3:0]  bsel [16];
    logic [31:0] got  [16];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        e_ack;
        logic        e_err;
        logic        chk_dat;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic cycle_start();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_idle();
        cyc = 0; stb = 0; we = 0; adr = 0; dat_ms = 0; sel = 0; cti = 0; bte = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Word index of beat i: linear counts through the RAM, wrap-k cycles inside its aligned block.
    function automatic int waddr(input int a0, input logic [1:0] b, input int i);
        int k;
        if (b == 2'b00) return (a0 + i) % DEPTH;
        k = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : 16;
        return (a0 - (a0 % k)) + ((a0 % k) + i) % k;
    endfunction

    task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic g_ack, output logic g_err,
                          output logic [31:0] g_dat);
        cycle_start();
        cyc = 1; stb = 1; we = w; adr = a; dat_ms = d; sel = s; cti = 3'b000; bte = 2'b00;
        #2 chk("single_req_ack", ack, 0);
        cycle_start();
        #2;
        g_ack = ack; g_err = err; g_dat = dat_sm;
        cycle_start();
        drive_idle();
    endtask

    task automatic present(input logic w, input int a0, input logic [1:0] b, input int n, input int i);
        cyc = 1; stb = 1; we = w; bte = b;
        adr    = 32'(waddr(a0, b, i)) << 2;
        dat_ms = bdat[i];
        sel    = bsel[i];
        cti    = (i == n - 1) ? 3'b111 : 3'b010;
    endtask

    task automatic burst(input logic w, input int a0, input logic [1:0] b, input int n,
                         input int wait_after, input logic tail);
        int a;
        cycle_start();
        present(w, a0, b, n, 0);
        #2 chk("burst_req_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            cycle_start();
            if (i > 0) begin
                if (i - 1 == wait_after) begin
                    stb = 0;
                    #2 chk("burst_wait_ack", ack, 0);
                    cycle_start();
                end
                present(w, a0, b, n, i);
            end
            #2 chk($sformatf("burst_beat%0d_ack", i), ack, 1);
            got[i] = dat_sm;
            a = waddr(a0, b, i);
            if (w) m_mem[a] = merge(m_mem[a], bdat[i], bsel[i]);
        end
        cycle_start();
        if (tail) begin
            cyc = 1; stb = 1; we = 0; adr = 0; cti = 3'b000; bte = 2'b00;
            #2 chk("burst_after_last_ack", ack, 0);
            cycle_start();
        end
        drive_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic        g_ack, g_err;
        logic [31:0] g_dat;
        int          op, wa, n, a0, wt;
        logic [1:0]  b;
        logic        w;

        // Reset held with a live request: nothing may answer.
        sys_rst_n = 0;
        drive_idle();
        cyc = 1; stb = 1;
        repeat (3) cycle_start();
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_dat", dat_sm, 0);
        chk("rst_rty", rty, 0);
        sys_rst_n = 1;
        #2 chk("rel_req_ack", ack, 0);
        cycle_start();
        #2 chk("rel_first_ack", ack, 1);
        cycle_start();
        drive_idle();

        tbl[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h10, 32'h11223344, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h10, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'hDE22BE44};
        tbl[4]  = '{1'b1, 32'h0,  32'h1,        4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'h4,  32'h2,        4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h8,  32'h3,        4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 32'hC,  32'h4,        4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h8,  32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h3};
        tbl[9]  = '{1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDE22BE44};
`ifdef WSHB_RAM_ERR_EN
        tbl[10] = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'hDE22BE44};
        tbl[11] = '{1'b1, 32'h1000_0000, 32'hBAD0BAD0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 32'h0,  32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h1};
`else
        tbl[10] = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h1};
        tbl[11] = '{1'b1, 32'h1000_0000, 32'hBAD0BAD0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 32'h0,  32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hBAD0BAD0};
`endif
        tbl[13] = '{1'b1, 32'h0,  32'h1,        4'hF, 1'b1, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            single(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, g_ack, g_err, g_dat);
            chk($sformatf("vec%0d_ack", i), g_ack, tbl[i].e_ack);
            chk($sformatf("vec%0d_err", i), g_err, tbl[i].e_err);
            if (tbl[i].chk_dat) chk($sformatf("vec%0d_dat", i), g_dat, tbl[i].e_dat);
        end

        // Linear 4-beat read from word 0, then a classic request right behind it.
        for (int i = 0; i < 16; i++) begin bdat[i] = 0; bsel[i] = 4'hF; end
        burst(1'b0, 0, 2'b00, 4, -1, 1'b1);
        for (int i = 0; i < 4; i++) chk($sformatf("lin_dat%0d", i), got[i], 32'(i + 1));

        // Wrap-4 from word 2 with one wait cycle after the second beat.
        burst(1'b0, 2, 2'b01, 4, 1, 1'b0);
        chk("wrap_dat0", got[0], 32'h3);
        chk("wrap_dat1", got[1], 32'h4);
        chk("wrap_dat2", got[2], 32'h1);
        chk("wrap_dat3", got[3], 32'h2);

        // Preload words 0..127 through write bursts so the model knows every word.
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 16; i++) begin bdat[i] = $urandom; bsel[i] = 4'hF; end
            burst(1'b1, blk * 16, 2'b00, 16, -1, 1'b0);
        end

        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                wa = $urandom_range(0, 127);
                bdat[0] = $urandom;
                bsel[0] = 4'($urandom_range(0, 15));
                single(1'b1, 32'(wa) << 2, bdat[0], bsel[0], g_ack, g_err, g_dat);
                chk("rnd_wr_ack", g_ack, 1);
                m_mem[wa] = merge(m_mem[wa], bdat[0], bsel[0]);
            end else if (op == 1) begin
                wa = $urandom_range(0, 127);
                single(1'b0, 32'(wa) << 2, 32'h0, 4'($urandom_range(0, 15)), g_ack, g_err, g_dat);
                chk("rnd_rd_ack", g_ack, 1);
                chk("rnd_rd_dat", g_dat, m_mem[wa]);
            end else begin
                b  = 2'($urandom_range(0, 3));
                n  = $urandom_range(1, 16);
                w  = 1'($urandom_range(0, 1));
                wt = ($urandom_range(0, 1) != 0) ? $urandom_range(0, n - 1) : -1;
                a0 = (b == 2'b00) ? $urandom_range(0, 128 - n) : $urandom_range(0, 127);
                for (int i = 0; i < 16; i++) begin
                    bdat[i] = $urandom;
                    bsel[i] = 4'($urandom_range(0, 15));
                end
                burst(w, a0, b, n, wt, 1'b0);
                if (!w) begin
                    for (int i = 0; i < n; i++)
                        chk($sformatf("rnd_burst_dat%0d", i), got[i], m_mem[waddr(a0, b, i)]);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
